// File: rtl/percept_rx.sv
// Serial frame receiver: start bit, 8-bit address, DW-bit payload, stop bit.
// Qualified frames land in a one-entry valid/ready output buffer with sticky overflow.
module percept_rx #(
  parameter logic [7:0]  ADDR = 8'hAA,
  parameter int unsigned DW   = 16
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          in,
  output logic [DW-1:0] res_data,
  output logic [7:0]    res_addr,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          frame_err,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int unsigned AW      = 8;
  localparam int unsigned CNT_MAX = (DW > AW) ? DW : AW;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [AW-1:0] BCAST = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sh_addr_q, sh_addr_d;
  logic [DW-1:0] sh_data_q, sh_data_d;
  logic          done_q, done_d;
  logic          stop_q, stop_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic          res_valid_q, res_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          ovf_q, ovf_d;
  logic          addr_last_c, data_last_c;
  logic          qual_c, load_c, drop_c;

  assign addr_last_c = (cnt_q == CW'(AW - 1));
  assign data_last_c = (cnt_q == CW'(DW - 1));

  // State register
  always_ff @(posedge clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!in) state_d = S_ADDR;
      S_ADDR:  if (addr_last_c) state_d = S_DATA;
      S_DATA:  if (data_last_c) state_d = S_STOP;
      S_STOP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; a finished frame is resolved one cycle after STOP
  always_comb begin
    cnt_d     = cnt_q;
    sh_addr_d = sh_addr_q;
    sh_data_d = sh_data_q;
    done_d    = 1'b0;
    stop_d    = stop_q;
    case (state_q)
      S_ADDR: begin
        sh_addr_d = AW'({in, sh_addr_q} >> 1);
        cnt_d     = addr_last_c ? '0 : cnt_q + CW'(1);
      end
      S_DATA: begin
        sh_data_d = DW'({in, sh_data_q} >> 1);
        cnt_d     = data_last_c ? '0 : cnt_q + CW'(1);
      end
      S_STOP: begin
        stop_d = in;
        done_d = 1'b1;
      end
      default: cnt_d = '0;
    endcase

    qual_c = done_q && stop_q && ((sh_addr_q == ADDR) || (sh_addr_q == BCAST));
    load_c = qual_c && (!res_valid_q || res_ready);
    drop_c = qual_c && res_valid_q && !res_ready;

    res_data_d  = load_c ? sh_data_q : res_data_q;
    res_addr_d  = load_c ? sh_addr_q : res_addr_q;
    res_valid_d = res_valid_q;
    if (load_c)                       res_valid_d = 1'b1;
    else if (res_valid_q && res_ready) res_valid_d = 1'b0;
    frame_err_d = done_q && !stop_q;
    ovf_d       = ovf_q;
    if (drop_c)       ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q       <= '0;
      sh_addr_q   <= '0;
      sh_data_q   <= '0;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
      res_data_q  <= '0;
      res_addr_q  <= '0;
      res_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sh_addr_q   <= sh_addr_d;
      sh_data_q   <= sh_data_d;
      done_q      <= done_d;
      stop_q      <= stop_d;
      res_data_q  <= res_data_d;
      res_addr_q  <= res_addr_d;
      res_valid_q <= res_valid_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_addr  = res_addr_q;
  assign res_valid = res_valid_q;
  assign frame_err = frame_err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_percept_rx.sv
// Directed bench for percept_rx: latency, filtering, framing errors, overflow,
// back-to-back frames and mid-frame reset.
module tb_percept_rx;

  logic        clk;
  logic        rst;
  logic        rx_in;
  logic [15:0] res_data;
  logic [7:0]  res_addr;
  logic        res_valid;
  logic        res_ready;
  logic        frame_err;
  logic        ovf;
  logic        ovf_clr;

  int unsigned nchk  = 0;
  int unsigned npass = 0;
  int unsigned v_rise = 0;
  int unsigned e_cnt  = 0;
  logic        prev_v = 1'b0;

  percept_rx #(.ADDR(8'hAA), .DW(16)) dut (
    .clk       (clk),
    .Rst       (rst),
    .in        (rx_in),
    .res_data  (res_data),
    .res_addr  (res_addr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .frame_err (frame_err),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count res_valid rising edges and frame_err cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (res_valid === 1'b1 && prev_v === 1'b0) v_rise++;
    if (frame_err === 1'b1) e_cnt++;
    prev_v = res_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else npass++;
  endtask

  // Drive one bit, let the rising edge sample it, return 1 time unit after the edge
  task automatic send_bit(input logic b);
    rx_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_body(input logic [7:0] a, input logic [15:0] d, input logic s);
    for (int i = 0; i < 8; i++)  send_bit(a[i]);
    for (int i = 0; i < 16; i++) send_bit(d[i]);
    send_bit(s);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic s);
    send_bit(1'b0);
    send_body(a, d, s);
  endtask

  logic [15:0] abort_d;

  initial begin
    rst = 1'b1; rx_in = 1'b1; res_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(res_valid), 32'h0);
    check("rst_data",  32'(res_data),  32'h0);
    check("rst_addr",  32'(res_addr),  32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_ovf",   32'(ovf),       32'h0);
    rst = 1'b0;
    send_bit(1'b1);

    // Basic accept and T+26 latency
    res_ready = 1'b1;
    send_frame(8'hAA, 16'h1234, 1'b1);
    check("t1_valid_t25", 32'(res_valid), 32'h0);
    send_bit(1'b1);
    check("t1_valid_t26", 32'(res_valid), 32'h1);
    check("t1_data",      32'(res_data),  32'h1234);
    check("t1_addr",      32'(res_addr),  32'hAA);
    check("t1_ferr",      32'(frame_err), 32'h0);
    send_bit(1'b1);
    check("t1_valid_drop", 32'(res_valid), 32'h0);

    // Address filter then broadcast
    send_frame(8'h55, 16'h1111, 1'b1);
    send_bit(1'b1);
    check("t2_miss_valid", 32'(res_valid), 32'h0);
    check("t2_miss_ferr",  32'(frame_err), 32'h0);
    check("t2_miss_data",  32'(res_data),  32'h1234);
    send_bit(1'b1);
    send_frame(8'hFF, 16'hBEEF, 1'b1);
    send_bit(1'b1);
    check("t2_bc_valid", 32'(res_valid), 32'h1);
    check("t2_bc_data",  32'(res_data),  32'hBEEF);
    check("t2_bc_addr",  32'(res_addr),  32'hFF);
    send_bit(1'b1);

    // Bad stop bit
    send_frame(8'hAA, 16'h7777, 1'b0);
    check("t3_ferr_t25", 32'(frame_err), 32'h0);
    send_bit(1'b1);
    check("t3_ferr_t26", 32'(frame_err), 32'h1);
    check("t3_valid",    32'(res_valid), 32'h0);
    send_bit(1'b1);
    check("t3_ferr_off", 32'(frame_err), 32'h0);
    check("t3_ferr_once", 32'(e_cnt), 32'h1);

    // Overflow with stalled consumer
    res_ready = 1'b0;
    send_frame(8'hAA, 16'h0001, 1'b1);
    send_bit(1'b1);
    check("t4_first_valid", 32'(res_valid), 32'h1);
    check("t4_first_data",  32'(res_data),  32'h0001);
    send_frame(8'hAA, 16'h0002, 1'b1);
    send_bit(1'b1);
    check("t4_hold_data", 32'(res_data),  32'h0001);
    check("t4_hold_vld",  32'(res_valid), 32'h1);
    check("t4_ovf_set",   32'(ovf),       32'h1);
    ovf_clr = 1'b1;
    send_bit(1'b1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf), 32'h0);
    res_ready = 1'b1;
    send_bit(1'b1);
    check("t4_consumed", 32'(res_valid), 32'h0);

    // Back-to-back frames, no idle gap
    send_frame(8'hAA, 16'hA5A5, 1'b1);
    send_bit(1'b0);
    check("t5_a_valid", 32'(res_valid), 32'h1);
    check("t5_a_data",  32'(res_data),  32'hA5A5);
    send_body(8'hAA, 16'h5A5A, 1'b1);
    check("t5_gap", 32'(res_valid), 32'h0);
    send_bit(1'b1);
    check("t5_b_valid", 32'(res_valid), 32'h1);
    check("t5_b_data",  32'(res_data),  32'h5A5A);
    send_bit(1'b1);
    check("t5_rises", 32'(v_rise), 32'd5);

    // Reset at data bit 7 aborts the frame
    abort_d = 16'h3C00;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'hAA >> i));
    for (int i = 0; i < 7; i++) send_bit(abort_d[i]);
    rst = 1'b1;
    send_bit(abort_d[7]);
    rst = 1'b0;
    rx_in = 1'b1;
    repeat (30) send_bit(1'b1);
    check("t6_no_valid", 32'(res_valid), 32'h0);
    check("t6_no_rise",  32'(v_rise),    32'd5);
    check("t6_no_ferr",  32'(e_cnt),     32'h1);
    check("t6_no_ovf",   32'(ovf),       32'h0);
    send_frame(8'hAA, 16'hCAFE, 1'b1);
    send_bit(1'b1);
    check("t6_valid", 32'(res_valid), 32'h1);
    check("t6_data",  32'(res_data),  32'hCAFE);
    check("t6_addr",  32'(res_addr),  32'hAA);
    send_bit(1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
